str_byte_serializer: RTL and testbench

//  Downstream consumer of the team's packed, null-padded string registers (e.g. {"hello world",16'b0}).

---
 rtl/str_pkg.sv | 18 +
 rtl/str_nul_find.sv | 26 ++
 rtl/str_byte_serializer.sv | 143 ++++++++++++++
 tb/tb_str_byte_serializer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/str_pkg.sv
// Shared definitions for the string-handling blocks: character width,
// the NUL terminator value and the serializer state type.
package str_pkg;

    localparam int CHAR_W = 8;
    localparam logic [CHAR_W-1:0] NUL_CHAR = 8'h00;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // True when a character is the string terminator.
    function automatic logic is_nul(input logic [CHAR_W-1:0] c);
        return (c == NUL_CHAR);
    endfunction

endpackage

// File: rtl/str_nul_find.sv
// Combinational first-NUL finder for a packed, left-justified string.
// Byte 0 is the MSB byte; the output is the index of the first NUL byte
// scanning from byte 0, or MAX_CHARS when the string has no NUL.
module str_nul_find
    import str_pkg::*;
#(
    parameter int MAX_CHARS = 13,
    parameter int LEN_W     = 4
) (
    input  logic [MAX_CHARS*CHAR_W-1:0] data,
    output logic [LEN_W-1:0]            len
);

    // Priority encoder: scan from the last byte towards byte 0 so that the
    // lowest-index NUL is the one that sticks.
    always_comb begin
        // NOTE: assign a default before the loop so every path drives len and no latch is inferred.
        len = LEN_W'(MAX_CHARS);
        for (int k = MAX_CHARS - 1; k >= 0; k--) begin
            if (is_nul(data[(MAX_CHARS - k)*CHAR_W - 1 -: CHAR_W])) begin
                len = LEN_W'(k);
            end
        end
    end

endmodule

// File: rtl/str_byte_serializer.sv
// Byte serializer for packed, NUL-padded string registers.
// Accepts one MAX_CHARS-byte string on the load handshake, then streams its
// characters (byte 0 first) on a valid/ready interface, stopping at the
// first NUL. A one-cycle done pulse marks the end of each string.
// Optional build macro STR_SER_EMIT_NUL_EN: when defined, the terminating
// NUL is sent as an extra final beat (not sent for a string with no NUL).
module str_byte_serializer
    import str_pkg::*;
#(
    parameter int MAX_CHARS = 13,
    parameter int LEN_W     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [MAX_CHARS*CHAR_W-1:0] load_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CHAR_W-1:0]           out_data,
    output logic                        out_last,
    output logic [LEN_W-1:0]            str_len,
    output logic                        done
);

    localparam int DATA_W = MAX_CHARS * CHAR_W;

    state_t              state_q;
    state_t              state_d;

    logic [DATA_W-1:0]   shift_q;
    logic [LEN_W-1:0]    remaining_q;
    logic                out_valid_q;
    logic [CHAR_W-1:0]   out_data_q;
    logic                out_last_q;
    logic [LEN_W-1:0]    str_len_q;
    logic                done_q;

    logic [LEN_W-1:0]    scan_len;
    logic [LEN_W-1:0]    load_beats;
    logic                load_fire;
    logic                beat_fire;
    logic                final_beat;

    str_nul_find #(
        .MAX_CHARS (MAX_CHARS),
        .LEN_W     (LEN_W)
    ) u_nul_find (
        .data (load_data),
        .len  (scan_len)
    );

    // Number of beats a freshly loaded string produces.
`ifdef STR_SER_EMIT_NUL_EN
    assign load_beats = (scan_len == LEN_W'(MAX_CHARS)) ? scan_len
                                                        : scan_len + LEN_W'(1);
`else
    assign load_beats = scan_len;
`endif

    assign load_fire  = load_valid && load_ready;
    assign beat_fire  = out_valid_q && out_ready;
    assign final_beat = beat_fire && (remaining_q == LEN_W'(1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: empty strings never leave IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (load_fire && (load_beats != '0)) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (final_beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: loads are accepted only in IDLE and never while reset is held.
    always_comb begin
        load_ready = (state_q == IDLE) && !rst;
    end

    // Datapath: capture on load, advance one character per accepted beat,
    // hold everything while the downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q     <= '0;
            remaining_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= NUL_CHAR;
            out_last_q  <= 1'b0;
            str_len_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load_fire) begin
                shift_q     <= load_data;
                str_len_q   <= scan_len;
                remaining_q <= load_beats;
                if (load_beats != '0) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= load_data[DATA_W-1 -: CHAR_W];
                    out_last_q  <= (load_beats == LEN_W'(1));
                end else begin
                    done_q <= 1'b1;
                end
            end else if (final_beat) begin
                remaining_q <= '0;
                out_valid_q <= 1'b0;
                out_data_q  <= NUL_CHAR;
                out_last_q  <= 1'b0;
                done_q      <= 1'b1;
            end else if (beat_fire) begin
                shift_q     <= shift_q << CHAR_W;
                remaining_q <= remaining_q - LEN_W'(1);
                out_data_q  <= shift_q[DATA_W-CHAR_W-1 -: CHAR_W];
                out_last_q  <= (remaining_q == LEN_W'(2));
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign str_len   = str_len_q;
    assign done      = done_q;

endmodule

// File: tb/tb_str_byte_serializer.sv
// Self-checking bench for str_byte_serializer: directed strings from the
// block's usage notes plus random strings, each checked beat by beat against
// a queue of expected characters derived from the string itself.
module tb_str_byte_serializer;

    localparam int MAX_CHARS = 13;
    localparam int LEN_W     = 4;
    localparam int DATA_W    = MAX_CHARS * 8;
    localparam int BUDGET    = 400;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_valid;
    logic              load_ready;
    logic [DATA_W-1:0] load_data;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic              out_last;
    logic [LEN_W-1:0]  str_len;
    logic              done;

    int n_checks = 0;
    int n_fail   = 0;

    str_byte_serializer #(
        .MAX_CHARS (MAX_CHARS),
        .LEN_W     (LEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .str_len    (str_len),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [DATA_W-1:0] s, input int k);
        return s[DATA_W-1-8*k -: 8];
    endfunction

    function automatic int first_nul(input logic [DATA_W-1:0] s);
        for (int k = 0; k < MAX_CHARS; k++) begin
            if (byte_at(s, k) == 8'h00) return k;
        end
        return MAX_CHARS;
    endfunction

    function automatic logic [DATA_W-1:0] rand_word();
        return DATA_W'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    function automatic logic [DATA_W-1:0] rand_string();
        logic [DATA_W-1:0] s;
        int len;
        len = $urandom_range(0, MAX_CHARS);
        for (int k = 0; k < MAX_CHARS; k++) begin
            if (k < len)       s[DATA_W-1-8*k -: 8] = 8'($urandom_range(1, 255));
            else if (k == len) s[DATA_W-1-8*k -: 8] = 8'h00;
            else               s[DATA_W-1-8*k -: 8] = 8'($urandom_range(0, 255));
        end
        return s;
    endfunction

    // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    // abort_after >= 0: assert reset once that many beats have been accepted.
    task automatic send_string(input logic [DATA_W-1:0] s, input int ready_mode,
                               input int abort_after, input string tag);
        logic [7:0] exp_q[$];
        int exp_len;
        int beats;
        int cycles;
        logic rdy;

        exp_len = first_nul(s);
        for (int k = 0; k < exp_len; k++) exp_q.push_back(byte_at(s, k));
`ifdef STR_SER_EMIT_NUL_EN
        if (exp_len < MAX_CHARS) exp_q.push_back(8'h00);
`endif

        check({tag, ":load_ready_idle"}, 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        load_data  = s;
        @(negedge clk);
        load_valid = 1'b0;
        load_data  = rand_word();
        check({tag, ":str_len"}, 32'(str_len), 32'(exp_len));

        if (exp_q.size() == 0) begin
            check({tag, ":done_empty"}, 32'(done), 32'd1);
            check({tag, ":valid_empty"}, 32'(out_valid), 32'd0);
            check({tag, ":ready_empty"}, 32'(load_ready), 32'd1);
            @(negedge clk);
            check({tag, ":done_cleared"}, 32'(done), 32'd0);
            check({tag, ":valid_after"}, 32'(out_valid), 32'd0);
            return;
        end

        beats  = 0;
        cycles = 0;
        while (beats < exp_q.size() && cycles < BUDGET) begin
            if (abort_after >= 0 && beats == abort_after) begin
                rst        = 1'b1;
                out_ready  = 1'b0;
                load_valid = 1'b0;
                #1;
                check({tag, ":rst_valid"}, 32'(out_valid), 32'd0);
                check({tag, ":rst_data"}, 32'(out_data), 32'd0);
                check({tag, ":rst_last"}, 32'(out_last), 32'd0);
                check({tag, ":rst_done"}, 32'(done), 32'd0);
                check({tag, ":rst_load_ready"}, 32'(load_ready), 32'd0);
                check({tag, ":rst_len"}, 32'(str_len), 32'd0);
                @(negedge clk);
                check({tag, ":rst_done_held"}, 32'(done), 32'd0);
                rst = 1'b0;
                #1;
                check({tag, ":post_rst_ready"}, 32'(load_ready), 32'd1);
                check({tag, ":post_rst_valid"}, 32'(out_valid), 32'd0);
                @(negedge clk);
                check({tag, ":post_rst_done"}, 32'(done), 32'd0);
                out_ready = 1'b1;
                return;
            end
            check({tag, ":valid"}, 32'(out_valid), 32'd1);
            check({tag, ":done_mid"}, 32'(done), 32'd0);
            check({tag, ":load_ready_busy"}, 32'(load_ready), 32'd0);
            check({tag, ":data"}, 32'(out_data), 32'(exp_q[beats]));
            check({tag, ":last"}, 32'(out_last), 32'(beats == exp_q.size() - 1));
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cycles % 4) == 0) || ((cycles % 4) == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready  = rdy;
            load_valid = 1'($urandom_range(0, 1));
            load_data  = rand_word();
            if (rdy) beats++;
            @(negedge clk);
            cycles++;
        end
        load_valid = 1'b0;
        out_ready  = 1'b1;
        check({tag, ":beat_count"}, 32'(beats), 32'(exp_q.size()));
        check({tag, ":done"}, 32'(done), 32'd1);
        check({tag, ":valid_end"}, 32'(out_valid), 32'd0);
        check({tag, ":ready_end"}, 32'(load_ready), 32'd1);
        @(negedge clk);
        check({tag, ":done_cleared"}, 32'(done), 32'd0);
        check({tag, ":valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [DATA_W-1:0] s_hello;
        logic [DATA_W-1:0] s_full;
        logic [DATA_W-1:0] s_embed;

        s_hello = {"hello world", 16'h0000};
        s_full  = "hello world!!";
        s_embed = {"hel", 8'h00, "o world", 8'h00, 8'h00};

        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        out_ready  = 1'b1;
        #1;
        check("reset:load_ready", 32'(load_ready), 32'd0);
        check("reset:out_valid", 32'(out_valid), 32'd0);
        check("reset:out_data", 32'(out_data), 32'd0);
        check("reset:done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("release:load_ready", 32'(load_ready), 32'd1);
        check("release:out_valid", 32'(out_valid), 32'd0);
        check("release:out_data", 32'(out_data), 32'd0);
        check("release:out_last", 32'(out_last), 32'd0);
        check("release:str_len", 32'(str_len), 32'd0);
        check("release:done", 32'(done), 32'd0);
        @(negedge clk);

        send_string(s_hello, 0, -1, "hello");
        send_string(s_full, 0, -1, "full");
        send_string('0, 0, -1, "empty");
        send_string(s_hello, 1, -1, "stall");
        send_string(s_embed, 0, -1, "embedded_nul");
        send_string(s_hello, 0, 3, "abort");
        send_string(s_hello, 2, -1, "after_abort");
        send_string(s_full, 1, -1, "full_stall");

        for (int i = 0; i < 24; i++) begin
            send_string(rand_string(), $urandom_range(0, 2), -1, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
